// File: rtl/disp7s_scan_if.sv
// Bus bundle between a display-data producer and the disp7s_scan controller.
// The producer drives the frame data and controls. The controller drives the
// decoder nibble, the digit selects and the frame marker.
interface disp7s_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic                  lz_en;
  logic [3:0]            nibble;
  logic [DIGITS-1:0]     an;
  logic                  frame;

  modport master (output load, data, lz_en, input nibble, an, frame);
  modport slave  (input load, data, lz_en, output nibble, an, frame);
endinterface

// File: rtl/disp7s_scan.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// It shows one digit per slot, blanks the start of each slot against ghosting,
// and swaps in new frame data only at frame boundaries.
//
// r_cnt/r_idx hold the slot position that the *next* clock edge will present.
// Every output is registered from that position and from the display value
// that is valid after the edge. An edge is a frame start when r_cnt and
// r_idx are both zero.
module disp7s_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input logic           clk,
  input logic           rst_n,
  disp7s_scan_if.slave  bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = 4 * DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [DW-1:0]     r_disp;
  logic [DW-1:0]     r_shad;
  logic              r_pend;
  logic              r_started;
  logic [3:0]        r_nibble;
  logic [DIGITS-1:0] r_an;
  logic              r_frame;

  logic [CW-1:0]     w_cnt_next;
  logic [IW-1:0]     w_idx_next;
  logic [DW-1:0]     w_disp_next;
  logic [DW-1:0]     w_shad_next;
  logic              w_pend_next;
  logic              w_frame_edge;
  logic [DIGITS-1:0] w_supp;
  logic              w_show;
  logic [3:0]        w_nibble_next;
  logic [DIGITS-1:0] w_an_next;

  assign w_frame_edge = (r_cnt == '0) && (r_idx == '0);

  // Slot counter and digit index advance.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_cnt_next = r_cnt + 1'b1;
    w_idx_next = r_idx;
    if (r_cnt == CNT_LAST) begin
      w_cnt_next = '0;
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Double buffer: loads are parked in the shadow until a frame start. A load
  // on the frame-start edge itself goes straight to the display.
  always_comb begin
    w_disp_next = r_disp;
    w_shad_next = r_shad;
    w_pend_next = r_pend;
    if (w_frame_edge) begin
      if (bus.load) begin
        w_disp_next = bus.data;
      end else if (r_pend) begin
        w_disp_next = r_shad;
      end
      w_pend_next = 1'b0;
    end else if (bus.load) begin
      w_shad_next = bus.data;
      w_pend_next = 1'b1;
    end
  end

  // Leading-zero suppression: scan down from the top digit while every digit
  // seen so far is zero. Digit 0 always stays lit.
  always_comb begin
    logic v_zero;
    v_zero = 1'b1;
    w_supp = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_zero = v_zero && (w_disp_next[4*i +: 4] == 4'h0);
      if (i != 0) w_supp[i] = bus.lz_en && v_zero;
    end
  end

  // Output decode from the next-state slot position and display value.
  always_comb begin
    w_nibble_next = w_disp_next[{r_idx, 2'b00} +: 4];
    w_show        = (int'(r_cnt) >= BLANK) && !w_supp[r_idx];
    w_an_next     = w_show ? (DIGITS'(1) << r_idx) : '0;
  end

  // State and registered outputs. Reset clears everything, including any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_disp    <= '0;
      r_shad    <= '0;
      r_pend    <= 1'b0;
      r_started <= 1'b0;
      r_nibble  <= '0;
      r_an      <= '0;
      r_frame   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values no matter the statement order.
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_disp    <= w_disp_next;
      r_shad    <= w_shad_next;
      r_pend    <= w_pend_next;
      r_started <= 1'b1;
      r_nibble  <= w_nibble_next;
      r_an      <= w_an_next;
      r_frame   <= w_frame_edge && r_started;
    end
  end

  assign bus.nibble = r_nibble;
  assign bus.an     = r_an;
  assign bus.frame  = r_frame;
endmodule

// File: tb/tb_disp7s_scan.sv
// Self-checking bench for disp7s_scan. A cycle-indexed reference model
// (slot = k / PRESCALE, digit = slot % DIGITS, last load before each frame
// start wins) is compared on every clock. Directed scenarios pin exact cycles.
// A second instance with PRESCALE=1 and BLANK=0 checks the gapless rotation.
module tb_disp7s_scan;
  localparam int D  = 4;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int FP = D * P;

  logic clk;
  logic rst_n;
  logic rst2_n;
  logic lz;
  int   cyc;
  int   n_checks;
  int   n_fail;

  disp7s_scan_if #(.DIGITS(D)) bus ();
  disp7s_scan_if #(.DIGITS(D)) bus2 ();

  disp7s_scan #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  disp7s_scan #(.DIGITS(D), .PRESCALE(1), .BLANK(0)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, got, exp, cyc, $time);
    end
  endtask

  // Reference model, advanced once per rising edge.
  int          m_k;
  int          m_last_cycle;
  logic [15:0] m_disp;
  logic [15:0] m_last_data;
  int          m_slot;
  int          m_idx;
  int          m_pos;
  int          m_hi;
  logic        m_ld;
  logic [15:0] m_d;
  logic        m_lz;
  logic [3:0]  e_nib;
  logic [3:0]  e_an;
  logic        e_frame;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_k          = 0;
      m_last_cycle = -1;
      m_disp       = '0;
      m_last_data  = '0;
      #1;
      check("rst_nibble", 32'(bus.nibble), 32'd0);
      check("rst_an",     32'(bus.an),     32'd0);
      check("rst_frame",  32'(bus.frame),  32'd0);
    end else begin
      m_ld = bus.load;
      m_d  = bus.data;
      m_lz = bus.lz_en;
      if (m_k % FP == 0) begin
        if (m_ld) m_disp = m_d;
        else if (m_k > 0 && m_last_cycle > m_k - FP) m_disp = m_last_data;
      end
      if (m_ld) begin
        m_last_data  = m_d;
        m_last_cycle = m_k;
      end
      m_slot = m_k / P;
      m_idx  = m_slot % D;
      m_pos  = m_k % P;
      m_hi   = 0;
      for (int i = 0; i < D; i++)
        if (((m_disp >> (4 * i)) & 16'hF) != 16'h0) m_hi = i;
      e_nib   = 4'((m_disp >> (4 * m_idx)) & 16'hF);
      e_an    = ((m_pos >= B) && !(m_lz && m_idx > m_hi)) ? 4'(1 << m_idx) : 4'd0;
      e_frame = (m_k > 0) && (m_k % FP == 0);
      #1;
      check("model_nibble", 32'(bus.nibble), 32'(e_nib));
      check("model_an",     32'(bus.an),     32'(e_an));
      check("model_frame",  32'(bus.frame),  32'(e_frame));
      m_k++;
    end
  end

  // One clock: drive inputs on the falling edge, then settle past the rising edge.
  task automatic step(input logic ld, input logic [15:0] d);
    @(negedge clk);
    bus.load  = ld;
    bus.data  = d;
    bus.lz_en = lz;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step(1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.load = 1'b0;
    bus.data = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc   = -1;
  endtask

  initial begin
    logic [15:0] d;
    logic        ld;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = -1;
    lz        = 1'b0;
    rst_n     = 1'b1;
    rst2_n    = 1'b1;
    bus.load  = 1'b0;
    bus.data  = '0;
    bus.lz_en = 1'b0;
    bus2.load  = 1'b0;
    bus2.data  = '0;
    bus2.lz_en = 1'b0;
    #1;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    #1;
    check("rst2_an", 32'(bus2.an), 32'd0);

    // Reset and plain scan.
    do_reset();
    run_to(1);  check("scan_an_c1",  32'(bus.an), 32'h0);
    run_to(2);  check("scan_an_c2",  32'(bus.an), 32'h1);
    run_to(7);  check("scan_an_c7",  32'(bus.an), 32'h1);
    run_to(8);  check("scan_an_c8",  32'(bus.an), 32'h0);
    run_to(10); check("scan_an_c10", 32'(bus.an), 32'h2);
    run_to(26); check("scan_an_c26", 32'(bus.an), 32'h8);
    run_to(31); check("scan_frame_c31", 32'(bus.frame), 32'h0);
    run_to(32); check("scan_frame_c32", 32'(bus.frame), 32'h1);
    run_to(34); check("scan_an_c34", 32'(bus.an), 32'h1);

    // Deferred load.
    do_reset();
    run_to(4);
    step(1'b1, 16'h1234);
    run_to(31); check("defer_nib_c31", 32'(bus.nibble), 32'h0);
    run_to(32); check("defer_nib_c32", 32'(bus.nibble), 32'h4);
    run_to(40); check("defer_nib_c40", 32'(bus.nibble), 32'h3);
    run_to(48); check("defer_nib_c48", 32'(bus.nibble), 32'h2);
    run_to(56); check("defer_nib_c56", 32'(bus.nibble), 32'h1);

    // Overwrite, then bypass on a frame-start edge.
    do_reset();
    run_to(19);
    step(1'b1, 16'h1111);
    run_to(24);
    step(1'b1, 16'h2222);
    run_to(32); check("ovw_nib_c32", 32'(bus.nibble), 32'h2);
    run_to(63);
    step(1'b1, 16'hABCD);
    check("bypass_nib_c64", 32'(bus.nibble), 32'hD);
    run_to(72); check("bypass_nib_c72", 32'(bus.nibble), 32'hC);

    // Leading-zero suppression.
    do_reset();
    lz = 1'b1;
    run_to(2);
    step(1'b1, 16'h0050);
    run_to(34); check("lz_nib_c34", 32'(bus.nibble), 32'h0);
                check("lz_an_c34",  32'(bus.an),     32'h1);
    run_to(40); check("lz_nib_c40", 32'(bus.nibble), 32'h5);
    run_to(42); check("lz_an_c42",  32'(bus.an),     32'h2);
    run_to(50); check("lz_an_c50",  32'(bus.an),     32'h0);
    run_to(58); check("lz_an_c58",  32'(bus.an),     32'h0);
    step(1'b1, 16'h0000);
    run_to(66); check("lz0_an_c66", 32'(bus.an), 32'h1);
    run_to(74); check("lz0_an_c74", 32'(bus.an), 32'h0);
    lz = 1'b0;
    run_to(82); check("lzoff_an_c82", 32'(bus.an), 32'h4);

    // Mid-frame reset.
    do_reset();
    step(1'b1, 16'h5678);
    check("mid_nib_c0", 32'(bus.nibble), 32'h8);
    run_to(13); check("mid_nib_c13", 32'(bus.nibble), 32'h7);
                check("mid_an_c13",  32'(bus.an),     32'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an",     32'(bus.an),     32'h0);
    check("mid_rst_nibble", 32'(bus.nibble), 32'h0);
    check("mid_rst_frame",  32'(bus.frame),  32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc   = -1;
    run_to(2); check("mid_after_an_c2",  32'(bus.an),     32'h1);
    run_to(8); check("mid_after_nib_c8", 32'(bus.nibble), 32'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 640; n++) begin
      ld = ($urandom_range(0, 5) == 0);
      d  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d[15:4]  = '0;
        1: d[15:8]  = '0;
        2: d[15:12] = '0;
        default: ;
      endcase
      if ($urandom_range(0, 19) == 0) lz = ~lz;
      step(ld, d);
    end

    // PRESCALE=1, BLANK=0 instance: gapless rotation.
    @(posedge clk);
    #2;
    rst2_n = 1'b1;
    @(negedge clk);
    bus2.load = 1'b1;
    bus2.data = 16'h4321;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #2;
      check("p1_an",     32'(bus2.an),     32'(1 << (k % 4)));
      check("p1_nibble", 32'(bus2.nibble), 32'((k % 4) + 1));
      check("p1_frame",  32'(bus2.frame),  32'((k > 0) && (k % 4 == 0)));
      @(negedge clk);
      bus2.load = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
